// File: rtl/fifo_word_packer_if.sv
// Byte-FIFO read port, flush request and word-wide valid/ready output of the packer.
// master = packer side, slave = FIFO/downstream side.
interface fifo_word_packer_if #(
  parameter int DATA_W = 8,
  parameter int BYTES  = 4
);
  logic                     fifo_empty;
  logic                     fifo_ren;
  logic [DATA_W-1:0]        fifo_rdata;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W*BYTES-1:0]  out_data;
  logic [BYTES-1:0]         out_keep;
  logic                     out_last;

  modport master (
    input  fifo_empty, fifo_rdata, flush, out_ready,
    output fifo_ren, out_valid, out_data, out_keep, out_last
  );
  modport slave (
    output fifo_empty, fifo_rdata, flush, out_ready,
    input  fifo_ren, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops bytes from a 1-cycle-latency FIFO and packs BYTES of them little-endian into a word.
// A flush closes a partial word early with a keep mask and out_last set.
module fifo_word_packer #(
  parameter int DATA_W = 8,
  parameter int BYTES  = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_word_packer_if.master bus
);
  localparam int            CW    = $clog2(BYTES + 1);
  localparam logic [CW:0]   FULL  = (CW+1)'(BYTES);
  localparam logic [1:0]    FILL  = 2'd0;
  localparam logic [1:0]    DRAIN = 2'd1;
  localparam logic [1:0]    OUT   = 2'd2;

  logic [1:0]                   state;
  logic [CW-1:0]                cnt;
  logic                         pend;
  logic                         flush_req;
  logic                         last;
  logic                         ren;
  logic [BYTES-1:0][DATA_W-1:0] data;
  logic [BYTES-1:0]             keep;
  logic [CW:0]                  held;

  // Bytes owned after this edge: already captured plus the one landing now.
  assign held = {1'b0, cnt} + (CW+1)'(pend);
  assign ren  = rst && (state == FILL) && !bus.fifo_empty && (held < FULL) && !flush_req;

  assign bus.fifo_ren  = ren;
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = data;
  assign bus.out_keep  = keep;
  assign bus.out_last  = last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      cnt       <= '0;
      pend      <= 1'b0;
      flush_req <= 1'b0;
      last      <= 1'b0;
      data      <= '0;
      keep      <= '0;
    end else begin
      pend <= ren;
      // pend is never set in OUT, so capture cannot collide with the handshake clear
      if (pend) begin
        for (int i = 0; i < BYTES; i++) begin
          if (cnt == CW'(i)) begin
            data[i] <= bus.fifo_rdata;
            keep[i] <= 1'b1;
          end
        end
        cnt <= cnt + CW'(1);
      end
      case (state)
        FILL: begin
          if (held == FULL) begin
            state     <= OUT;
            last      <= bus.flush;
            flush_req <= bus.flush;
          end else if (bus.flush && (held != '0 || ren)) begin
            flush_req <= 1'b1;
            if (ren) begin
              state <= DRAIN;
            end else begin
              state <= OUT;
              last  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          state <= OUT;
          last  <= 1'b1;
        end
        OUT: begin
          if (bus.out_ready) begin
            state     <= FILL;
            cnt       <= '0;
            keep      <= '0;
            data      <= '0;
            last      <= 1'b0;
            flush_req <= 1'b0;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) held <= FULL);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: queue-based byte FIFO model plus expected-word scoreboard.
module tb_fifo_word_packer;
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   ren_cnt  = 0;
  logic [7:0] fq[$];
  word_t      sb[$];

  fifo_word_packer_if #(.DATA_W(8), .BYTES(4)) bus ();
  fifo_word_packer #(.DATA_W(8), .BYTES(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Advance one cycle from a negedge to the next; models the FIFO's 1-cycle read latency.
  task automatic step();
    logic r;
    #1 r = bus.fifo_ren;
    @(posedge clk);
    #1;
    if (r && fq.size() > 0) bus.fifo_rdata = fq.pop_front();
    bus.fifo_empty = (fq.size() == 0);
    ren_cnt += int'(r);
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic wait_word(output int n);
    n = -1;
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid) begin
        n = k;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.out_ready = 1'b1; bus.flush = 1'b0; bus.fifo_rdata = '0; bus.fifo_empty = 1'b1;
    push(8'h5A);
    @(negedge clk); @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.fifo_ren, bus.out_last} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl got valid/ren/last=%b want 000", {bus.out_valid, bus.fifo_ren, bus.out_last});
    end
    checks++;
    if ({bus.out_data, bus.out_keep} !== 36'h0) begin
      failures++; $display("FAIL reset_data got %h want 0", {bus.out_data, bus.out_keep});
    end
    fq.delete(); bus.fifo_empty = 1'b1;
    rst = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_full_word();
    int n, r0; word_t exp;
    r0 = ren_cnt;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    sb.push_back('{32'h44332211, 4'b1111, 1'b0});
    wait_word(n);
    exp = sb.pop_front();
    checks++;
    if (n < 0 || {bus.out_data, bus.out_keep, bus.out_last} !== exp) begin
      failures++; $display("FAIL full_word got %h (n=%0d) want %h", {bus.out_data, bus.out_keep, bus.out_last}, n, exp);
    end
    checks++;
    if (ren_cnt - r0 !== 4) begin
      failures++; $display("FAIL full_word_ren got %0d want 4", ren_cnt - r0);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL full_word_accept got valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_flush_partial();
    int n; word_t exp;
    push(8'hA1); push(8'hA2);
    sb.push_back('{32'h0000A2A1, 4'b0011, 1'b1});
    step(); step();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    wait_word(n);
    exp = sb.pop_front();
    checks++;
    if (n < 0 || {bus.out_data, bus.out_keep, bus.out_last} !== exp) begin
      failures++; $display("FAIL flush_partial got %h (n=%0d) want %h", {bus.out_data, bus.out_keep, bus.out_last}, n, exp);
    end
    step();
  endtask

  task automatic test_flush_drain();
    int n, r0; word_t exp;
    r0 = ren_cnt;
    push(8'hA1); push(8'hA2);
    sb.push_back('{32'h0000A2A1, 4'b0011, 1'b1});
    step();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    wait_word(n);
    exp = sb.pop_front();
    checks++;
    if (n < 0 || {bus.out_data, bus.out_keep, bus.out_last} !== exp) begin
      failures++; $display("FAIL flush_drain got %h (n=%0d) want %h", {bus.out_data, bus.out_keep, bus.out_last}, n, exp);
    end
    checks++;
    if (ren_cnt - r0 !== 2) begin
      failures++; $display("FAIL flush_drain_ren got %0d want 2", ren_cnt - r0);
    end
    step();
  endtask

  task automatic test_backpressure();
    int n; word_t exp;
    bus.out_ready = 1'b0;
    push(8'h55); push(8'h66); push(8'h77); push(8'h88); push(8'h99);
    sb.push_back('{32'h88776655, 4'b1111, 1'b0});
    sb.push_back('{32'h00000099, 4'b0001, 1'b1});
    wait_word(n);
    exp = sb.pop_front();
    checks++;
    if (n < 0 || {bus.out_data, bus.out_keep, bus.out_last} !== exp) begin
      failures++; $display("FAIL bp_word got %h (n=%0d) want %h", {bus.out_data, bus.out_keep, bus.out_last}, n, exp);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({bus.out_valid, bus.fifo_ren, bus.out_data} !== {1'b1, 1'b0, 32'h88776655} || fq.size() != 1) begin
        failures++; $display("FAIL bp_hold c=%0d got valid=%b ren=%b data=%h occ=%0d want 1 0 88776655 1",
                             c, bus.out_valid, bus.fifo_ren, bus.out_data, fq.size());
      end
    end
    bus.out_ready = 1'b1;
    step();
    checks++;
    if ({bus.out_valid, bus.fifo_ren} !== 2'b01) begin
      failures++; $display("FAIL bp_resume got valid/ren=%b want 01", {bus.out_valid, bus.fifo_ren});
    end
    step();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    wait_word(n);
    exp = sb.pop_front();
    checks++;
    if (n < 0 || {bus.out_data, bus.out_keep, bus.out_last} !== exp) begin
      failures++; $display("FAIL bp_tail got %h (n=%0d) want %h", {bus.out_data, bus.out_keep, bus.out_last}, n, exp);
    end
    step();
  endtask

  task automatic test_flush_empty();
    int n; logic seen; word_t exp;
    seen = 1'b0;
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    for (int c = 0; c < 10; c++) begin
      seen |= bus.out_valid;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL flush_empty got valid seen=%b want 0", seen);
    end
    push(8'h21); push(8'h22); push(8'h23); push(8'h24);
    sb.push_back('{32'h24232221, 4'b1111, 1'b0});
    wait_word(n);
    exp = sb.pop_front();
    checks++;
    if (n < 0 || {bus.out_data, bus.out_keep, bus.out_last} !== exp) begin
      failures++; $display("FAIL flush_not_queued got %h (n=%0d) want %h", {bus.out_data, bus.out_keep, bus.out_last}, n, exp);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int n; word_t exp;
    push(8'hE1); push(8'hE2); push(8'hE3);
    repeat (4) step();
    push(8'hE4);
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.fifo_ren, bus.out_data, bus.out_keep} !== 38'h0) begin
      failures++; $display("FAIL reset_mid got valid=%b ren=%b data=%h keep=%b want all 0",
                           bus.out_valid, bus.fifo_ren, bus.out_data, bus.out_keep);
    end
    fq.delete(); bus.fifo_empty = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    sb.push_back('{32'h04030201, 4'b1111, 1'b0});
    wait_word(n);
    exp = sb.pop_front();
    checks++;
    if (n < 0 || {bus.out_data, bus.out_keep, bus.out_last} !== exp) begin
      failures++; $display("FAIL reset_mid_word got %h (n=%0d) want %h", {bus.out_data, bus.out_keep, bus.out_last}, n, exp);
    end
    step();
  endtask

  task automatic test_empty_stall();
    int n; logic seen; word_t exp;
    seen = 1'b0;
    push(8'hC1); push(8'hC2);
    sb.push_back('{32'hC4C3C2C1, 4'b1111, 1'b0});
    repeat (3) step();
    for (int c = 0; c < 8; c++) begin
      seen |= bus.out_valid;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL stall_valid got valid seen=%b want 0", seen);
    end
    push(8'hC3); push(8'hC4);
    wait_word(n);
    exp = sb.pop_front();
    checks++;
    if (n < 0 || {bus.out_data, bus.out_keep, bus.out_last} !== exp) begin
      failures++; $display("FAIL stall_word got %h (n=%0d) want %h", {bus.out_data, bus.out_keep, bus.out_last}, n, exp);
    end
    step();
  endtask

  task automatic test_flush_full();
    int n; logic seen; word_t exp;
    seen = 1'b0;
    push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
    sb.push_back('{32'hD4D3D2D1, 4'b1111, 1'b1});
    repeat (4) step();
    bus.flush = 1'b1; step(); bus.flush = 1'b0;
    wait_word(n);
    exp = sb.pop_front();
    checks++;
    if (n < 0 || {bus.out_data, bus.out_keep, bus.out_last} !== exp) begin
      failures++; $display("FAIL flush_full got %h (n=%0d) want %h", {bus.out_data, bus.out_keep, bus.out_last}, n, exp);
    end
    step();
    for (int c = 0; c < 5; c++) begin
      seen |= bus.out_valid;
      step();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL flush_full_extra got valid seen=%b want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int n1, n2; word_t exp;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    sb.push_back('{32'h13121110, 4'b1111, 1'b0});
    sb.push_back('{32'h17161514, 4'b1111, 1'b0});
    wait_word(n1);
    exp = sb.pop_front();
    checks++;
    if (n1 < 0 || {bus.out_data, bus.out_keep, bus.out_last} !== exp) begin
      failures++; $display("FAIL b2b_first got %h (n=%0d) want %h", {bus.out_data, bus.out_keep, bus.out_last}, n1, exp);
    end
    step();
    wait_word(n2);
    exp = sb.pop_front();
    checks++;
    if (n2 < 0 || {bus.out_data, bus.out_keep, bus.out_last} !== exp) begin
      failures++; $display("FAIL b2b_second got %h (n=%0d) want %h", {bus.out_data, bus.out_keep, bus.out_last}, n2, exp);
    end
    checks++;
    if (1 + n2 != 6) begin
      failures++; $display("FAIL b2b_period got %0d cycles want 6", 1 + n2);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_flush_partial();
    test_flush_drain();
    test_backpressure();
    test_flush_empty();
    test_reset_mid();
    test_empty_stall();
    test_flush_full();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
